mmio_uart_tx: RTL
=================

// Module: mmio_uart_tx
// PURPOSE
//  Memory-mapped UART transmitter: the sink for byte stores the core makes to its debug-output address.
//  Accepted bytes are buffered in a FIFO and serialized 8N1, LSB first, on tx.
//  Sits beside JZJCoreF's memory bus so test programs can print results instead of being checked only via VCD.
// PARAMETERS
//  CLOCK_HZ    50_000_000  core clock frequency
//  BAUD        115_200     line rate; CLKS_PER_BIT = CLOCK_HZ/BAUD (integer division), must be >= 2
//  FIFO_DEPTH  16          FIFO entries; power of two, >= 2
// PORTS
//  clock           in   1                         core clock, rising edge
//  reset           in   1                         asynchronous, active-low reset
//  write_enable    in   1                         byte store strobe from the core
//  write_data      in   8                         byte to transmit
//  overflow_clear  in   1                         clears the sticky overflow flag
//  fifo_full       out  1                         FIFO holds FIFO_DEPTH entries (registered)
//  fifo_count      out  $clog2(FIFO_DEPTH)+1      entries queued, excluding the byte being sent
//  overflow        out  1                         sticky: a write was dropped
//  tx_busy         out  1                         serializer not IDLE
//  tx              out  1                         serial line, idle high
// BEHAVIOUR
//  - Reset (async assert, sync-safe release): tx=1, tx_busy=0, fifo_count=0, fifo_full=0, overflow=0, FSM=IDLE.
//    Assertion mid-frame aborts the frame immediately and flushes the FIFO; nothing resumes after release.
//  - Write acceptance: accepted at a rising edge iff write_enable && !fifo_full, with fifo_full the registered
//    value before that edge. Accepted writes enqueue at that edge. A write seen while full is dropped and sets
//    overflow, even if a pop occurs at the same edge.
//  - overflow: set by a dropped write; cleared by overflow_clear. If both happen at the same edge, set wins.
//  - Serializer FSM, all outputs registered:
//    IDLE : tx=1. If fifo_count!=0, pop the head into the shift register -> START.
//    START: tx=0 for CLKS_PER_BIT cycles -> DATA.
//    DATA : 8 bits, LSB first, each CLKS_PER_BIT cycles; 3-bit bit index -> STOP after bit 7.
//    STOP : tx=1 for CLKS_PER_BIT cycles. At the end, if the FIFO is non-empty, pop -> START directly
//           (no idle cycle between frames); else -> IDLE.
//  - Frame length is exactly 10*CLKS_PER_BIT cycles. tx_busy=1 in START/DATA/STOP.
//  - Latency: a write accepted at edge N into an empty FIFO in IDLE is popped at edge N+1.
//    tx falls after edge N+1. fifo_count reads 1 after edge N and 0 after edge N+1.
//  - Simultaneous push and pop: count is unchanged; the pointers wrap modulo FIFO_DEPTH.
//  - Baud counter: counts 0..CLKS_PER_BIT-1 and reloads on every state/bit transition.
//    Width is $clog2(CLKS_PER_BIT).
// STRUCTURE
//  - Package mmio_uart_pkg: tx_state_t enum {IDLE, START, DATA, STOP}; localparams DATA_BITS=8 and
//    FRAME_BITS=10; function clks_per_bit(CLOCK_HZ, BAUD).
//  - Sub-module uart_tx_fifo: synchronous FIFO (push/pop/full/empty/count) with the same clock/reset.
//    The serializer FSM and baud counter live in mmio_uart_tx.
//  - Elaboration-time assertions on CLKS_PER_BIT >= 2 and FIFO_DEPTH being a power of two.
// TESTING  (CLOCK_HZ=400, BAUD=100 -> CLKS_PER_BIT=4; FIFO_DEPTH=4 unless stated)
//  1. Reset held then released, no writes -> tx=1, tx_busy=0, fifo_count=0, overflow=0 for 100 cycles.
//  2. Single write 0xA5 -> tx=0 for 4 cycles from edge N+1; then 1,0,1,0,0,1,0,1 at 4 cycles each;
//     then 1 for 4 cycles. tx_busy high exactly 40 cycles.
//  3. Writes 0x55 then 0x0F on consecutive cycles -> two frames in 80 contiguous busy cycles.
//     The second start bit immediately follows the first stop bit.
//  4. Six writes 0x01..0x06 on consecutive cycles -> 0x01 popped, 0x02..0x05 queued (fifo_full=1),
//     0x06 dropped, overflow=1. Line carries 0x01..0x05 in order.
//  5. overflow_clear pulsed alone -> overflow=0 next cycle. Clear together with a dropped write while full
//     -> overflow stays 1.
//  6. reset asserted during DATA bit 3 of 0xC3 with 2 bytes queued -> tx=1 and fifo_count=0 without waiting
//     for a clock; no frame after release.

Source files
------------

// File: rtl/mmio_uart_pkg.sv
// Shared types and constants for the memory-mapped UART transmitter.
//   tx_state_t    : serializer states
//   DATA_BITS     : payload bits per frame
//   FRAME_BITS    : start + data + stop bits per frame
//   clks_per_bit(): clock cycles per serial bit
package mmio_uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam int unsigned DATA_BITS  = 8;
  localparam int unsigned FRAME_BITS = 10;

  // Integer division; any remainder shows up as baud-rate error on the line.
  function automatic int unsigned clks_per_bit(input int unsigned clock_hz,
                                               input int unsigned baud);
    return clock_hz / baud;
  endfunction

endpackage

// File: rtl/mmio_uart_tx_fifo.sv
// Synchronous byte FIFO feeding the UART serializer.
//   clock, reset  : rising-edge clock, async active-low reset (flushes contents)
//   push_i/data_i : enqueue a byte (caller guarantees not full)
//   pop_i         : dequeue the head (caller guarantees not empty)
//   head_c_o      : current head entry, combinational read of the storage
//   full_o        : registered, count == DEPTH
//   empty_o       : registered, count == 0
//   count_o       : registered entry count
module mmio_uart_tx_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           head_c_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, empty_q;

  // Pointer and occupancy update; pointers wrap naturally at a power-of-two depth.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state; full/empty are precomputed so they are clean register outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= (count_d == CNT_W'(DEPTH));
      empty_q  <= (count_d == '0);
    end
  end

  // Storage needs no reset: entries are only read once written.
  always_ff @(posedge clock) begin
    if (push_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign head_c_o = mem_q[rd_ptr_q];
  assign full_o   = full_q;
  assign empty_o  = empty_q;
  assign count_o  = count_q;

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: buffers byte stores from the core and
// serializes them 8N1, LSB first.
//   clock, reset   : rising-edge clock, async active-low reset
//   write_enable   : byte store strobe, write_data is the byte
//   overflow_clear : clears the sticky overflow flag (a same-edge drop wins)
//   fifo_full      : FIFO holds FIFO_DEPTH entries
//   fifo_count     : queued entries, not counting the byte on the line
//   overflow       : sticky, a write arrived while full and was dropped
//   tx_busy        : serializer is in START/DATA/STOP
//   tx             : serial line, idle high
module mmio_uart_tx
  import mmio_uart_pkg::*;
#(
  parameter int unsigned CLOCK_HZ   = 50_000_000,
  parameter int unsigned BAUD       = 115_200,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          write_enable,
  input  logic [7:0]                    write_data,
  input  logic                          overflow_clear,
  output logic                          fifo_full,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic                          tx_busy,
  output logic                          tx
);

  localparam int unsigned CPB    = clks_per_bit(CLOCK_HZ, BAUD);
  localparam int unsigned BAUD_W = $clog2(CPB);
  localparam int unsigned BIT_W  = $clog2(DATA_BITS);

  if (CPB < 2) begin : g_cpb_check
    $error("mmio_uart_tx: CLOCK_HZ/BAUD must be at least 2");
  end
  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_depth_check
    $error("mmio_uart_tx: FIFO_DEPTH must be a power of two >= 2");
  end

  tx_state_t              state_q, state_d;
  logic [BAUD_W-1:0]      baud_q, baud_d;
  logic [BIT_W-1:0]       bit_q, bit_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   tx_q, tx_d;
  logic                   busy_q, busy_d;
  logic                   overflow_q, overflow_d;

  logic                   push_c, pop_c, drop_c, baud_last_c;
  logic [DATA_BITS-1:0]   head_c;
  logic                   fifo_empty;

  // Acceptance uses the registered full flag, so a same-edge pop never rescues a write.
  assign push_c = write_enable && !fifo_full;
  assign drop_c = write_enable &&  fifo_full;

  mmio_uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_BITS)
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .push_i   (push_c),
    .data_i   (write_data),
    .pop_i    (pop_c),
    .head_c_o (head_c),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty),
    .count_o  (fifo_count)
  );

  assign baud_last_c = (baud_q == BAUD_W'(CPB - 1));

  // Serializer next-state; tx/busy are computed one step ahead so they leave as registers.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    pop_c   = 1'b0;

    unique case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (!fifo_empty) begin
          pop_c   = 1'b1;
          shift_d = head_c;
          baud_d  = '0;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
          state_d = START;
        end
      end
      START: begin
        if (baud_last_c) begin
          baud_d  = '0;
          bit_d   = '0;
          tx_d    = shift_q[0];
          state_d = DATA;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      DATA: begin
        if (baud_last_c) begin
          baud_d = '0;
          if (bit_q == BIT_W'(DATA_BITS - 1)) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            bit_d   = bit_q + BIT_W'(1);
            shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
            tx_d    = shift_q[1];
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      STOP: begin
        if (baud_last_c) begin
          baud_d = '0;
          // Chain straight into the next start bit when more data is queued.
          if (!fifo_empty) begin
            pop_c   = 1'b1;
            shift_d = head_c;
            tx_d    = 1'b0;
            state_d = START;
          end else begin
            tx_d    = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      default: begin
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // Sticky overflow: a drop on the same edge as a clear keeps the flag set.
  always_comb begin
    overflow_d = overflow_q;
    if (overflow_clear) overflow_d = 1'b0;
    if (drop_c)         overflow_d = 1'b1;
  end

  // State registers; reset drives the line idle immediately.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      overflow_q <= overflow_d;
    end
  end

  assign tx       = tx_q;
  assign tx_busy  = busy_q;
  assign overflow = overflow_q;

endmodule
